// File: rtl/uart_sched_pkg.sv
// uart_sched_pkg: shared widths and FSM state encoding for the uart transaction scheduler
package uart_sched_pkg;
    localparam int UART_DW = 8;
    localparam int UART_AW = 32;
    localparam int ID_W = 3;
    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, CLEAR = 2'd3} state_t;
endpackage

// File: rtl/rr_arbiter_onehot.sv
// rr_arbiter_onehot: combinational round-robin pick of the first request at or after ptr
module rr_arbiter_onehot import uart_sched_pkg::*; #(
    parameter int NREQ = 4
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] ptr,
    output logic [NREQ-1:0] onehot,
    output logic [ID_W-1:0] idx,
    output logic            any
);
    logic [ID_W-1:0] hi, lo;
    logic hi_v;
    // Descending scan leaves the lowest match in each candidate; hi covers [ptr..], lo the wrap.
    always_comb begin
        hi = '0;
        lo = '0;
        hi_v = 1'b0;
        any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo = ID_W'(i);
                any = 1'b1;
                if (ID_W'(i) >= ptr) begin
                    hi = ID_W'(i);
                    hi_v = 1'b1;
                end
            end
        end
        idx = hi_v ? hi : lo;
        onehot = any ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/uart_txn_sched.sv
// uart_txn_sched: round-robin sequencer sharing one uart among NREQ requesters
module uart_txn_sched import uart_sched_pkg::*; #(
    parameter int NREQ = 4,
    parameter int TIMEOUT = 4096,
    parameter int CLR_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*8-1:0]    req_data,
    output logic [NREQ-1:0]      gnt,
    output logic                 rsp_valid,
    output logic [ID_W-1:0]      rsp_id,
    output logic [UART_DW-1:0]   rsp_data,
    output logic [UART_AW-1:0]   rsp_addr,
    output logic                 rsp_err,
    output logic                 busy,
    output logic [15:0]          done_cnt,
    output logic                 uart_en,
    output logic                 uart_reset,
    output logic [UART_DW-1:0]   uart_data_in,
    input  logic [UART_DW-1:0]   uart_data_out,
    input  logic                 uart_done,
    input  logic [UART_AW-1:0]   uart_address
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam int KW = $clog2(CLR_CYCLES + 1);
    state_t state;
    logic [ID_W-1:0] rr_ptr, idx, a_idx;
    logic [NREQ-1:0] a_onehot, win;
    logic a_any;
    logic [CW-1:0] cnt;
    logic [KW-1:0] clr_cnt;
    logic [UART_DW-1:0] sel;
    logic fin;
    rr_arbiter_onehot #(.NREQ(NREQ)) arb (
        .req(req),
        .ptr(rr_ptr),
        .onehot(a_onehot),
        .idx(a_idx),
        .any(a_any)
    );
    always_comb begin
        sel = '0;
        for (int i = 0; i < NREQ; i++) sel |= a_onehot[i] ? req_data[8*i +: 8] : '0;
    end
    // done beats the timeout when both land in the same cycle
    assign fin = uart_done || cnt == CW'(TIMEOUT - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            rr_ptr <= '0;
            idx <= '0;
            win <= '0;
            cnt <= '0;
            clr_cnt <= '0;
            gnt <= '0;
            rsp_valid <= 1'b0;
            rsp_id <= '0;
            rsp_data <= '0;
            rsp_addr <= '0;
            rsp_err <= 1'b0;
            busy <= 1'b0;
            done_cnt <= '0;
            uart_en <= 1'b0;
            uart_reset <= 1'b1;
            uart_data_in <= '0;
        end else begin
            gnt <= '0;
            rsp_valid <= 1'b0;
            done_cnt <= done_cnt + 16'(state == RUN && uart_done);
            case (state)
                IDLE: begin
                    uart_reset <= 1'b0;
                    if (a_any) begin
                        idx <= a_idx;
                        win <= a_onehot;
                        uart_data_in <= sel;
                        busy <= 1'b1;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    gnt <= win;
                    rr_ptr <= idx == ID_W'(NREQ - 1) ? '0 : idx + ID_W'(1);
                    uart_en <= 1'b1;
                    cnt <= '0;
                    state <= RUN;
                end
                RUN: begin
                    cnt <= cnt + CW'(1);
                    if (fin) begin
                        rsp_valid <= 1'b1;
                        rsp_id <= idx;
                        rsp_err <= !uart_done;
                        rsp_data <= uart_done ? uart_data_out : '0;
                        rsp_addr <= uart_done ? uart_address : '0;
                        uart_en <= 1'b0;
                        uart_reset <= 1'b1;
                        clr_cnt <= '0;
                        state <= CLEAR;
                    end
                end
                CLEAR: begin
                    clr_cnt <= clr_cnt + KW'(1);
                    if (clr_cnt == KW'(CLR_CYCLES - 1)) begin
                        uart_reset <= 1'b0;
                        busy <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
